// File: rtl/reqslot_pkg.sv
// Shared helpers for request-slot arbiters: width derivation and one-hot encoding.
package reqslot_pkg;

  // Upper bound on sources handled by the generic one-hot encoder.
  localparam int unsigned MaxReq = 32;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned src_width(input int unsigned nreq);
    return (nreq < 2) ? 1 : clog2(nreq);
  endfunction

  function automatic int unsigned oh_to_idx(input logic [MaxReq-1:0] oh);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < MaxReq; i++) begin
      if (oh[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/reqslot_pick.sv
// Combinational slot picker: fixed lowest-index priority, or rotating priority
// starting at ptr_i when REQSLOT_RR_EN is defined.
module reqslot_pick
  import reqslot_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  localparam int unsigned SRCW = src_width(NREQ)
) (
  input  logic [NREQ-1:0] slot_v_i,
`ifdef REQSLOT_RR_EN
  input  logic [SRCW-1:0] ptr_i,
`endif
  output logic [NREQ-1:0] pick_o,
  output logic [SRCW-1:0] idx_o,
  output logic            any_o
);

  logic found;

  always_comb begin
    pick_o = '0;
    found  = 1'b0;
`ifdef REQSLOT_RR_EN
    for (int unsigned k = 0; k < NREQ; k++) begin
      logic [SRCW:0] sum;
      sum = {1'b0, ptr_i} + (SRCW+1)'(k);
      if (sum >= (SRCW+1)'(NREQ)) sum = sum - (SRCW+1)'(NREQ);
      if (!found && slot_v_i[sum[SRCW-1:0]]) begin
        pick_o[sum[SRCW-1:0]] = 1'b1;
        found                 = 1'b1;
      end
    end
`else
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!found && slot_v_i[k]) begin
        pick_o[k] = 1'b1;
        found     = 1'b1;
      end
    end
`endif
  end

  assign idx_o = SRCW'(oh_to_idx(MaxReq'(pick_o)));
  assign any_o = |slot_v_i;

endmodule

// File: rtl/reqslot_arb.sv
// One-deep request slot per source feeding a registered valid/ready output stage.
// Define REQSLOT_RR_EN for rotating-priority selection instead of fixed priority.
module reqslot_arb
  import reqslot_pkg::*;
#(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned DWIDTH = 32,
  localparam int unsigned SRCW  = src_width(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        in_valid,
  output logic [NREQ-1:0]        in_ready,
  input  logic [NREQ*DWIDTH-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DWIDTH-1:0]      out_data,
  output logic [SRCW-1:0]        out_src,
  output logic                   busy
);

  logic [NREQ-1:0]   slot_v_q, slot_v_d;
  logic [DWIDTH-1:0] slot_data_q [NREQ];
  logic [DWIDTH-1:0] slot_data_d [NREQ];
  logic              out_valid_q, out_valid_d;
  logic [DWIDTH-1:0] out_data_q, out_data_d;
  logic [SRCW-1:0]   out_src_q, out_src_d;

  logic [NREQ-1:0]   pick;
  logic [SRCW-1:0]   pick_idx;
  logic              any_v;
  logic              adv;

`ifdef REQSLOT_RR_EN
  logic [SRCW-1:0]   ptr_q, ptr_d;
`endif

  reqslot_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .slot_v_i (slot_v_q),
`ifdef REQSLOT_RR_EN
    .ptr_i    (ptr_q),
`endif
    .pick_o   (pick),
    .idx_o    (pick_idx),
    .any_o    (any_v)
  );

  assign adv = ~out_valid_q | out_ready;
  // A slot being drained this cycle can take a new request in the same cycle.
  assign in_ready = rst ? '0 : (~slot_v_q | (pick & {NREQ{adv}}));

  always_comb begin
    slot_v_d    = slot_v_q;
    slot_data_d = slot_data_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
`ifdef REQSLOT_RR_EN
    ptr_d       = ptr_q;
`endif
    if (adv) begin
      if (any_v) begin
        out_valid_d = 1'b1;
        out_data_d  = slot_data_q[pick_idx];
        out_src_d   = pick_idx;
        slot_v_d    = slot_v_q & ~pick;
`ifdef REQSLOT_RR_EN
        ptr_d       = (pick_idx == SRCW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
`endif
      end else begin
        out_valid_d = 1'b0;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (in_valid[i] && in_ready[i]) begin
        slot_v_d[i]    = 1'b1;
        slot_data_d[i] = in_data[i*DWIDTH +: DWIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_v_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      for (int i = 0; i < NREQ; i++) slot_data_q[i] <= '0;
`ifdef REQSLOT_RR_EN
      ptr_q       <= '0;
`endif
    end else begin
      slot_v_q    <= slot_v_d;
      slot_data_q <= slot_data_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
`ifdef REQSLOT_RR_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign busy      = |slot_v_q | out_valid_q;

endmodule

// File: tb/tb_reqslot_arb.sv
// Self-checking bench for reqslot_arb: per-cycle vector table, hand sequences for
// ordering/starvation/reset, and a per-source FIFO scoreboard on the output port.
module tb_reqslot_arb;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   in_valid;
  logic [3:0]   in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic [1:0]   out_src;
  logic         busy;

  reqslot_arb #(
    .NREQ   (4),
    .DWIDTH (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  src;
    logic [31:0] data;
  } sb_t;

  typedef struct {
    logic [3:0]  v;
    logic [31:0] base;
    logic        rdy;
    logic [3:0]  exp_rdy;
    logic        exp_ov;
    logic [1:0]  exp_src;
    logic [31:0] exp_data;
    logic        exp_busy;
  } vec_t;

  sb_t        sb[$];
  int         vectors = 0;
  int         errors  = 0;
  vec_t       tbl[10];
  logic [1:0] grants[$];
  logic [1:0] exp_order[3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Source i carries base + 16*i; accepted requests go to the scoreboard.
  task automatic cycle(input logic [3:0] v, input logic [31:0] base, input logic rdy);
    in_valid  = v;
    out_ready = rdy;
    for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = base + 32'(i * 16);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (v[i] && in_ready[i]) sb.push_back({2'(i), base + 32'(i * 16)});
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      int found;
      found = -1;
      for (int j = 0; j < sb.size(); j++) begin
        if (sb[j].src == out_src) begin
          found = j;
          break;
        end
      end
      vectors++;
      if (found < 0) begin
        errors++;
        $display("FAIL sb_unexpected: got src %0d data %0h, expected no output", out_src,
                 out_data);
      end else begin
        if (out_data !== sb[found].data) begin
          errors++;
          $display("FAIL sb_data src%0d: got %0h expected %0h", out_src, out_data,
                   sb[found].data);
        end
        sb.delete(found);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish within 200000 time units");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    int src1_in_stream;
    int first_src1;

    rst = 1'b1; in_valid = '0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_out_src", 32'(out_src), 32'h0);
    chk("rst_out_data", out_data, 32'h0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'hF);
    tick();

    // Single request from source 0.
    cycle(4'b0001, 32'hA0, 1'b0);
    chk("a_in_ready0", 32'(in_ready[0]), 32'h1);
    tick();
    cycle(4'b0000, 32'h0, 1'b0);
    chk("a_ov_n", 32'(out_valid), 32'h0);
    chk("a_busy_n", 32'(busy), 32'h1);
    tick();
    cycle(4'b0000, 32'h0, 1'b0);
    chk("a_ov_n1", 32'(out_valid), 32'h1);
    chk("a_data", out_data, 32'hA0);
    chk("a_src", 32'(out_src), 32'h0);
    chk("a_busy_n1", 32'(busy), 32'h1);
    tick();
    cycle(4'b0000, 32'h0, 1'b1);
    chk("a_data_stall", out_data, 32'hA0);
    chk("a_busy_stall", 32'(busy), 32'h1);
    tick();
    cycle(4'b0000, 32'h0, 1'b0);
    chk("a_ov_done", 32'(out_valid), 32'h0);
    chk("a_busy_done", 32'(busy), 32'h0);

    // Source 1 alone first, so a rotating pointer sits at 2 before the burst.
    cycle(4'b0010, 32'hB0, 1'b1); tick();
    cycle(4'b0000, 32'h0, 1'b1);  tick();
    cycle(4'b0000, 32'h0, 1'b1);  tick();
`ifdef REQSLOT_RR_EN
    exp_order[0] = 2'd2; exp_order[1] = 2'd3; exp_order[2] = 2'd1;
`else
    exp_order[0] = 2'd1; exp_order[1] = 2'd2; exp_order[2] = 2'd3;
`endif
    cycle(4'b1110, 32'hD0, 1'b1); tick();
    cycle(4'b0000, 32'h0, 1'b1);
    chk("b_ov_capture", 32'(out_valid), 32'h0);
    tick();
    for (int i = 0; i < 3; i++) begin
      cycle(4'b0000, 32'h0, 1'b1);
      chk("b_ov", 32'(out_valid), 32'h1);
      chk("b_order", 32'(out_src), 32'(exp_order[i]));
      tick();
    end
    cycle(4'b0000, 32'h0, 1'b1);
    chk("b_ov_end", 32'(out_valid), 32'h0);

`ifndef REQSLOT_RR_EN
    // Stall, fill every slot, then release.
    tbl[0] = '{4'hF, 32'h100, 1'b0, 4'hF, 1'b0, 2'd0, 32'h0,   1'b0};
    tbl[1] = '{4'h0, 32'h0,   1'b0, 4'h1, 1'b0, 2'd0, 32'h0,   1'b1};
    tbl[2] = '{4'hF, 32'h200, 1'b0, 4'h1, 1'b1, 2'd0, 32'h100, 1'b1};
    tbl[3] = '{4'hF, 32'h300, 1'b0, 4'h0, 1'b1, 2'd0, 32'h100, 1'b1};
    tbl[4] = '{4'h0, 32'h0,   1'b1, 4'h1, 1'b1, 2'd0, 32'h100, 1'b1};
    tbl[5] = '{4'h0, 32'h0,   1'b1, 4'h3, 1'b1, 2'd0, 32'h200, 1'b1};
    tbl[6] = '{4'h0, 32'h0,   1'b1, 4'h7, 1'b1, 2'd1, 32'h110, 1'b1};
    tbl[7] = '{4'h0, 32'h0,   1'b1, 4'hF, 1'b1, 2'd2, 32'h120, 1'b1};
    tbl[8] = '{4'h0, 32'h0,   1'b1, 4'hF, 1'b1, 2'd3, 32'h130, 1'b1};
    tbl[9] = '{4'h0, 32'h0,   1'b1, 4'hF, 1'b0, 2'd0, 32'h0,   1'b0};
    for (int r = 0; r < 10; r++) begin
      cycle(tbl[r].v, tbl[r].base, tbl[r].rdy);
      chk($sformatf("t%0d_in_ready", r), 32'(in_ready), 32'(tbl[r].exp_rdy));
      chk($sformatf("t%0d_out_valid", r), 32'(out_valid), 32'(tbl[r].exp_ov));
      chk($sformatf("t%0d_busy", r), 32'(busy), 32'(tbl[r].exp_busy));
      if (tbl[r].exp_ov) begin
        chk($sformatf("t%0d_out_src", r), 32'(out_src), 32'(tbl[r].exp_src));
        chk($sformatf("t%0d_out_data", r), out_data, tbl[r].exp_data);
      end
      tick();
    end
`endif

    // Source 0 back-to-back at full rate.
    for (int i = 0; i < 8; i++) begin
      cycle(4'b0001, 32'h500 + 32'(i), 1'b1);
      chk("c_in_ready0", 32'(in_ready[0]), 32'h1);
      if (i >= 2) chk("c_ov", 32'(out_valid), 32'h1);
      tick();
    end
    repeat (3) begin
      cycle(4'b0000, 32'h0, 1'b1);
      tick();
    end
    chk("c_busy_drained", 32'(busy), 32'h0);

    // Source 0 always valid, source 1 once.
    k = 0;
    grants.delete();
    for (int c = 0; c < 8; c++) begin
      cycle((c == 0) ? 4'b0011 : 4'b0001, 32'h600 + 32'(k), 1'b1);
      if (in_ready[0]) k++;
      tick();
      if (out_valid) grants.push_back(out_src);
    end
    src1_in_stream = 0;
    foreach (grants[g]) if (grants[g] == 2'd1) src1_in_stream++;
    repeat (4) begin
      cycle(4'b0000, 32'h0, 1'b1);
      tick();
      if (out_valid) grants.push_back(out_src);
    end
    first_src1 = -1;
    for (int g = grants.size() - 1; g >= 0; g--) if (grants[g] == 2'd1) first_src1 = g;
`ifdef REQSLOT_RR_EN
    chk("d_src1_within_2", 32'(first_src1 >= 0 && first_src1 <= 1), 32'h1);
`else
    chk("d_src1_starved", 32'(src1_in_stream), 32'h0);
    chk("d_src1_late", 32'(first_src1 >= 7), 32'h1);
`endif
    chk("d_busy_drained", 32'(busy), 32'h0);

    // Reset with slots full and the output stalled.
    cycle(4'hF, 32'h700, 1'b0); tick();
    cycle(4'hF, 32'h800, 1'b0); tick();
    chk("e_busy_full", 32'(busy), 32'h1);
    rst = 1'b1;
    cycle(4'h0, 32'h0, 1'b0);
    chk("e_in_ready_rst", 32'(in_ready), 32'h0);
    tick();
    rst = 1'b0;
    sb.delete();
    cycle(4'h0, 32'h0, 1'b1);
    chk("e_out_valid", 32'(out_valid), 32'h0);
    chk("e_busy", 32'(busy), 32'h0);
    chk("e_in_ready", 32'(in_ready), 32'hF);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("e_no_spurious", 32'(out_valid), 32'h0);
    end

    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
